sobel_frame_sequencer: RTL and testbench
========================================

// Module: sobel_frame_sequencer
// PURPOSE
//  Frame-level controller for TOP_RGB_GRAY_SOBEL. Takes a frame command from the AXI register side,
//  drives ACCESS_CONTROL and the start pulses, and waits for each stage's done flag before moving on.
//  The stages run in order: colour load, RGB->GRAY, GRAY->SOBEL, readback window.
//  Latches the threshold, guards every stage with a timeout and reports status/IRQ to AXI.
// PARAMETERS
//  TIMEOUT_CYC   131072  max cycles spent in any wait state before error (frame = 76800 px)
//  THR_W         18      threshold width
//  FRAME_CNT_W   16      completed-frame counter width
// PORTS
//  i_CLK            in   1      system clock
//  i_RSTn           in   1      asynchronous active-low reset
//  cmd_start        in   1      1-cycle pulse: begin frame (colour BRAM load phase)
//  cmd_abort        in   1      1-cycle pulse: abandon frame, return to IDLE
//  cmd_rd_release   in   1      1-cycle pulse: AXI finished reading Sobel BRAM
//  thr_in           in   THR_W  threshold from AXI register
//  done_color       in   1      DONE_WRITE_COLOR_BRAM_SIGN
//  done_gray        in   1      DONE_WRITE_GRAY_BRAM_SIGN
//  done_sobel       in   1      DONE_PROCESSING_SOBEL
//  access_ctrl      out  2      ACCESS_CONTROL: 00 AXI/load+readback, 01 RGB2GRAY, 10 GRAY2SOBEL
//  start_rgb2gray   out  1      AXI_START_RGB2GRAY pulse
//  start_gray2sobel out  1      AXI_START_GRAY2SOBEL pulse
//  thr_out          out  THR_W  THRESHOLD_TOP; held stable for the whole frame
//  busy             out  1      high in every state except IDLE and ERROR
//  rd_window        out  1      high in READOUT (AXI may read Sobel BRAM)
//  irq_done         out  1      1-cycle pulse on entry to READOUT
//  err_timeout      out  1      sticky; cleared by the next accepted cmd_start
//  err_stage        out  2      stage that timed out: 0 load, 1 gray, 2 sobel
//  frame_cnt        out  FRAME_CNT_W  completed frames; wraps at 2^W-1 -> 0
// BEHAVIOUR
//  Reset values: all outputs 0, state=IDLE, access_ctrl=00, thr_out=0.
//  Done inputs are registered and rising-edge detected (done_*_re). A done level left high from the
//   previous frame never advances the FSM.
//  FSM (registered outputs; each transition takes effect 1 cycle after its cause):
//   IDLE:       cmd_start -> LOAD; latch thr_out<=thr_in; clear err_*; clear timer.
//   LOAD:       access 00; done_color_re -> GO_GRAY.
//   GO_GRAY:    access 01, start_rgb2gray=1 for exactly this cycle -> RUN_GRAY.
//   RUN_GRAY:   access 01; done_gray_re -> GO_SOBEL.
//   GO_SOBEL:   access 10, start_gray2sobel=1 for exactly this cycle -> RUN_SOBEL.
//   RUN_SOBEL:  access 10; done_sobel_re -> READOUT; frame_cnt++.
//   READOUT:    access 00, rd_window=1; cmd_rd_release -> IDLE. No timeout in this state.
//   ERROR:      access 00, busy=0; cmd_start -> LOAD (same actions as from IDLE).
//  access_ctrl changes in the same cycle the start pulse asserts, never after it.
//  Timer: clears on every state entry and counts in LOAD/RUN_GRAY/RUN_SOBEL. Reaching TIMEOUT_CYC-1
//   without the expected done -> ERROR, err_timeout=1, err_stage=current stage.
//  cmd_abort in any state except IDLE -> IDLE on next edge: access 00, pulses suppressed,
//   frame_cnt unchanged. Abort wins over start, done and timeout in the same cycle.
//  cmd_start outside IDLE/ERROR is ignored; thr_out is not re-latched.
//  Done edge and timeout in the same cycle: done wins.
//  Async reset mid-frame: immediate return to the reset values. Downstream stages are expected to
//   reset on the same i_RSTn.
// STRUCTURE
//  Shared package sobel_pkg: typedef enum logic[1:0] access_t {ACC_AXI=2'b00, ACC_GRAY=2'b01,
//   ACC_SOBEL=2'b10}; typedef enum seq_state_t; localparams FRAME_PIXELS=76800, IMG_W=320, IMG_H=240.
//  One sub-module: seq_edge_det (3x registered rising-edge detector for the done inputs).
//  Timer, frame counter and FSM are implemented inline.
// TESTING
//  1 Nominal: start, thr_in=100000; done_color@+10, done_gray@+76810, done_sobel@+153700 -> access
//    00,01,10,00 in order; each start pulse exactly 1 cycle; irq_done once; frame_cnt=1; thr_out=100000.
//  2 Stale done: hold done_gray=1 from frame 1 into frame 2 -> FSM stays in RUN_GRAY until the level
//    falls and rises again.
//  3 Timeout: TIMEOUT_CYC=64, never assert done_sobel -> ERROR after 64 cycles in RUN_SOBEL,
//    err_stage=2, access 00; next start clears err_timeout.
//  4 Abort in RUN_GRAY with done_gray_re in the same cycle -> IDLE, no start_gray2sobel, frame_cnt unchanged.
//  5 cmd_start during RUN_SOBEL with thr_in=5 -> ignored; thr_out keeps its latched value.
//  6 i_RSTn low for 3 cycles mid RUN_SOBEL -> all outputs 0 immediately; new frame then completes
//    normally; frame_cnt force-set to 16'hFFFF then one frame completes -> reads 0.

Source files
------------

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module : sobel_pkg
// Brief  : Shared types and constants for the Sobel frame sequencer.
//          access_t    - ACCESS_CONTROL bus encoding
//          seq_state_t - frame sequencer FSM states
//          state_access() - ACCESS_CONTROL value owned by each state
// Rev    : 1.0  initial release
// ============================================================================
package sobel_pkg;

  localparam int FRAME_PIXELS = 76800;
  localparam int IMG_W        = 320;
  localparam int IMG_H        = 240;

  typedef enum logic [1:0] {
    ACC_AXI   = 2'b00,
    ACC_GRAY  = 2'b01,
    ACC_SOBEL = 2'b10
  } access_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_GO_GRAY   = 3'd2,
    S_RUN_GRAY  = 3'd3,
    S_GO_SOBEL  = 3'd4,
    S_RUN_SOBEL = 3'd5,
    S_READOUT   = 3'd6,
    S_ERROR     = 3'd7
  } seq_state_t;

  // The GO_* states already own the bus of the stage they launch, so the
  // access switch and the start pulse always land in the same cycle.
  function automatic access_t state_access(input seq_state_t s);
    access_t a;
    case (s)
      S_GO_GRAY, S_RUN_GRAY:   a = ACC_GRAY;
      S_GO_SOBEL, S_RUN_SOBEL: a = ACC_SOBEL;
      default:                 a = ACC_AXI;
    endcase
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : sobel_frame_sequencer_if
// Brief  : Command / stage-handshake / status bundle of the frame sequencer.
//          master : AXI register side and processing stages (drive commands
//                   and done flags, observe control and status)
//          slave  : the sequencer itself
// Rev    : 1.0  initial release
// ============================================================================
interface sobel_frame_sequencer_if #(
  parameter int THR_W       = 18,
  parameter int FRAME_CNT_W = 16
);
  import sobel_pkg::*;

  // commands from the AXI register block
  logic                   cmd_start;
  logic                   cmd_abort;
  logic                   cmd_rd_release;
  logic [THR_W-1:0]       thr_in;
  // stage completion levels
  logic                   done_color;
  logic                   done_gray;
  logic                   done_sobel;
  // control to the processing top
  access_t                access_ctrl;
  logic                   start_rgb2gray;
  logic                   start_gray2sobel;
  logic [THR_W-1:0]       thr_out;
  // status to the AXI register block
  logic                   busy;
  logic                   rd_window;
  logic                   irq_done;
  logic                   err_timeout;
  logic [1:0]             err_stage;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output cmd_start, cmd_abort, cmd_rd_release, thr_in,
    output done_color, done_gray, done_sobel,
    input  access_ctrl, start_rgb2gray, start_gray2sobel, thr_out,
    input  busy, rd_window, irq_done, err_timeout, err_stage, frame_cnt
  );

  modport slave (
    input  cmd_start, cmd_abort, cmd_rd_release, thr_in,
    input  done_color, done_gray, done_sobel,
    output access_ctrl, start_rgb2gray, start_gray2sobel, thr_out,
    output busy, rd_window, irq_done, err_timeout, err_stage, frame_cnt
  );

endinterface
`default_nettype wire

// File: rtl/seq_edge_det.sv
`default_nettype none
// ============================================================================
// Module : seq_edge_det
// Brief  : N-bit registered rising-edge detector for the stage done levels.
//          A level that is already high when watching starts produces no
//          edge; it must fall and rise again.
// Ports  : clk   - system clock
//          rst_n - asynchronous active-low reset
//          din   - raw done levels
//          rise  - one-cycle pulse per 0->1 transition of the registered level
// Rev    : 1.0  initial release
// ============================================================================
module seq_edge_det #(
  parameter int N = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [N-1:0] din,
  output logic      [N-1:0] rise
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic r_d1;
    logic r_d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_d1 <= 1'b0;
        r_d2 <= 1'b0;
      end else begin
        r_d1 <= din[gi];
        r_d2 <= r_d1;
      end
    end

    assign rise[gi] = r_d1 & ~r_d2;
  end

endmodule
`default_nettype wire

// File: rtl/sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module : sobel_frame_sequencer
// Brief  : Frame-level controller for TOP_RGB_GRAY_SOBEL. Sequences colour
//          load -> RGB2GRAY -> GRAY2SOBEL -> readback window, owns
//          ACCESS_CONTROL and the start pulses, latches the threshold per
//          frame, guards every wait state with a timeout and reports status.
// Ports  : i_CLK   - system clock
//          i_RSTn  - asynchronous active-low reset
//          bus     - sobel_frame_sequencer_if.slave (commands, done flags,
//                    access/start/threshold control, busy/irq/error/count)
// Rev    : 1.0  initial release
// ============================================================================
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int TIMEOUT_CYC = 131072,
  parameter int THR_W       = 18,
  parameter int FRAME_CNT_W = 16
) (
  input  wire logic               i_CLK,
  input  wire logic               i_RSTn,
  sobel_frame_sequencer_if.slave  bus
);

  localparam int              TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  // done edges: [0] colour, [1] gray, [2] sobel
  logic [2:0]             w_rise;

  seq_state_t             r_state;
  seq_state_t             w_state_d;
  logic [TMR_W-1:0]       r_timer;
  logic                   w_timer_last;
  logic                   w_accept_start;
  logic                   w_timeout;
  logic                   w_frame_done;
  logic [1:0]             w_stage;

  access_t                r_access;
  logic                   r_start_gray;
  logic                   r_start_sobel;
  logic [THR_W-1:0]       r_thr;
  logic                   r_busy;
  logic                   r_rd_window;
  logic                   r_irq;
  logic                   r_err;
  logic [1:0]             r_err_stage;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  seq_edge_det #(.N(3)) u_edge (
    .clk   (i_CLK),
    .rst_n (i_RSTn),
    .din   ({bus.done_sobel, bus.done_gray, bus.done_color}),
    .rise  (w_rise)
  );

  assign w_timer_last = (r_timer == TMR_LAST);

  // State register
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic. Abort is checked first so it beats start, done and
  // timeout; within a wait state the done edge is checked before the timer.
  always_comb begin
    w_state_d      = r_state;
    w_accept_start = 1'b0;
    w_timeout      = 1'b0;
    w_frame_done   = 1'b0;
    w_stage        = 2'd0;

    if (bus.cmd_abort && (r_state != S_IDLE)) begin
      w_state_d = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (bus.cmd_start) begin
            w_state_d      = S_LOAD;
            w_accept_start = 1'b1;
          end
        end
        S_LOAD: begin
          w_stage = 2'd0;
          if (w_rise[0]) begin
            w_state_d = S_GO_GRAY;
          end else if (w_timer_last) begin
            w_state_d = S_ERROR;
            w_timeout = 1'b1;
          end
        end
        S_GO_GRAY: w_state_d = S_RUN_GRAY;
        S_RUN_GRAY: begin
          w_stage = 2'd1;
          if (w_rise[1]) begin
            w_state_d = S_GO_SOBEL;
          end else if (w_timer_last) begin
            w_state_d = S_ERROR;
            w_timeout = 1'b1;
          end
        end
        S_GO_SOBEL: w_state_d = S_RUN_SOBEL;
        S_RUN_SOBEL: begin
          w_stage = 2'd2;
          if (w_rise[2]) begin
            w_state_d    = S_READOUT;
            w_frame_done = 1'b1;
          end else if (w_timer_last) begin
            w_state_d = S_ERROR;
            w_timeout = 1'b1;
          end
        end
        S_READOUT: begin
          if (bus.cmd_rd_release) begin
            w_state_d = S_IDLE;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they change on
  // the same edge as the state register; an abort therefore drops any
  // pending start pulse and returns the bus to AXI immediately.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_timer       <= '0;
      r_access      <= ACC_AXI;
      r_start_gray  <= 1'b0;
      r_start_sobel <= 1'b0;
      r_thr         <= '0;
      r_busy        <= 1'b0;
      r_rd_window   <= 1'b0;
      r_irq         <= 1'b0;
      r_err         <= 1'b0;
      r_err_stage   <= 2'd0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_state_d != r_state) begin
        r_timer <= '0;
      end else if ((r_state == S_LOAD) || (r_state == S_RUN_GRAY) ||
                   (r_state == S_RUN_SOBEL)) begin
        r_timer <= r_timer + TMR_W'(1);
      end

      r_access      <= state_access(w_state_d);
      r_start_gray  <= (w_state_d == S_GO_GRAY);
      r_start_sobel <= (w_state_d == S_GO_SOBEL);
      r_busy        <= (w_state_d != S_IDLE) && (w_state_d != S_ERROR);
      r_rd_window   <= (w_state_d == S_READOUT);
      r_irq         <= (w_state_d == S_READOUT) && (r_state != S_READOUT);

      if (w_accept_start) begin
        r_thr <= bus.thr_in;
      end

      if (w_accept_start) begin
        r_err       <= 1'b0;
        r_err_stage <= 2'd0;
      end else if (w_timeout) begin
        r_err       <= 1'b1;
        r_err_stage <= w_stage;
      end

      // natural binary wrap from all-ones to zero
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

  assign bus.access_ctrl      = r_access;
  assign bus.start_rgb2gray   = r_start_gray;
  assign bus.start_gray2sobel = r_start_sobel;
  assign bus.thr_out          = r_thr;
  assign bus.busy             = r_busy;
  assign bus.rd_window        = r_rd_window;
  assign bus.irq_done         = r_irq;
  assign bus.err_timeout      = r_err;
  assign bus.err_stage        = r_err_stage;
  assign bus.frame_cnt        = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_sobel_frame_sequencer
// Brief  : Directed bench for sobel_frame_sequencer. The main instance uses a
//          64-cycle timeout; a second instance with a 2-bit frame counter
//          shares every input so the counter wrap is reached in 4 frames.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sobel_frame_sequencer;
  import sobel_pkg::*;

  localparam int THR_W = 18;
  localparam int FCW   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_frame_sequencer_if #(.THR_W(THR_W), .FRAME_CNT_W(FCW)) bus ();
  sobel_frame_sequencer_if #(.THR_W(THR_W), .FRAME_CNT_W(2))   bus_w ();

  sobel_frame_sequencer #(.TIMEOUT_CYC(64), .THR_W(THR_W), .FRAME_CNT_W(FCW)) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  sobel_frame_sequencer #(.TIMEOUT_CYC(64), .THR_W(THR_W), .FRAME_CNT_W(2)) dut_w (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus_w)
  );

  assign bus_w.cmd_start      = bus.cmd_start;
  assign bus_w.cmd_abort      = bus.cmd_abort;
  assign bus_w.cmd_rd_release = bus.cmd_rd_release;
  assign bus_w.thr_in         = bus.thr_in;
  assign bus_w.done_color     = bus.done_color;
  assign bus_w.done_gray      = bus.done_gray;
  assign bus_w.done_sobel     = bus.done_sobel;

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [THR_W-1:0] thr);
    bus.thr_in    = thr;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  // One-cycle done pulse; on return the FSM has just taken the done edge.
  task automatic pulse_done(input int which);
    case (which)
      0:       bus.done_color = 1'b1;
      1:       bus.done_gray  = 1'b1;
      default: bus.done_sobel = 1'b1;
    endcase
    tick();
    bus.done_color = 1'b0;
    bus.done_gray  = 1'b0;
    bus.done_sobel = 1'b0;
    tick();
  endtask

  task automatic run_frame(input logic [THR_W-1:0] thr, input int exp_cnt);
    pulse_start(thr);
    repeat (3) tick();
    pulse_done(0);
    chk("rf_go_gray_start", bus.start_rgb2gray, 1);
    tick();
    repeat (3) tick();
    pulse_done(1);
    chk("rf_go_sobel_start", bus.start_gray2sobel, 1);
    tick();
    repeat (3) tick();
    pulse_done(2);
    chk("rf_irq", bus.irq_done, 1);
    chk("rf_frame_cnt", bus.frame_cnt, exp_cnt);
    tick();
    bus.cmd_rd_release = 1'b1;
    tick();
    bus.cmd_rd_release = 1'b0;
    chk("rf_idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.cmd_start      = 1'b0;
    bus.cmd_abort      = 1'b0;
    bus.cmd_rd_release = 1'b0;
    bus.thr_in         = '0;
    bus.done_color     = 1'b0;
    bus.done_gray      = 1'b0;
    bus.done_sobel     = 1'b0;

    // ---------------- reset state
    repeat (3) tick();
    chk("rst_access", bus.access_ctrl, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_thr", bus.thr_out, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_err", bus.err_timeout, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // ---------------- 1: nominal frame; done_gray left high afterwards
    pulse_start(18'd100000);
    chk("t1_load_busy", bus.busy, 1);
    chk("t1_load_access", bus.access_ctrl, 0);
    chk("t1_thr_latched", bus.thr_out, 100000);
    repeat (8) tick();
    pulse_done(0);
    chk("t1_go_gray_access", bus.access_ctrl, 1);
    chk("t1_go_gray_start", bus.start_rgb2gray, 1);
    tick();
    chk("t1_run_gray_start", bus.start_rgb2gray, 0);
    chk("t1_run_gray_access", bus.access_ctrl, 1);
    repeat (20) tick();
    bus.done_gray = 1'b1;
    tick();
    tick();
    chk("t1_go_sobel_access", bus.access_ctrl, 2);
    chk("t1_go_sobel_start", bus.start_gray2sobel, 1);
    tick();
    chk("t1_run_sobel_start", bus.start_gray2sobel, 0);
    chk("t1_run_sobel_cnt", bus.frame_cnt, 0);
    repeat (30) tick();
    pulse_done(2);
    chk("t1_readout_access", bus.access_ctrl, 0);
    chk("t1_readout_window", bus.rd_window, 1);
    chk("t1_readout_irq", bus.irq_done, 1);
    chk("t1_frame_cnt", bus.frame_cnt, 1);
    tick();
    chk("t1_irq_single", bus.irq_done, 0);
    chk("t1_window_held", bus.rd_window, 1);
    bus.cmd_rd_release = 1'b1;
    tick();
    bus.cmd_rd_release = 1'b0;
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_window", bus.rd_window, 0);
    chk("t1_thr_kept", bus.thr_out, 100000);

    // ---------------- 2: stale done_gray level must not advance
    pulse_start(18'd1234);
    repeat (3) tick();
    pulse_done(0);
    tick();
    repeat (10) tick();
    chk("t2_stale_access", bus.access_ctrl, 1);
    chk("t2_stale_nostart", bus.start_gray2sobel, 0);
    bus.done_gray = 1'b0;
    tick();
    tick();
    chk("t2_low_access", bus.access_ctrl, 1);
    pulse_done(1);
    chk("t2_new_edge_start", bus.start_gray2sobel, 1);
    tick();

    // ---------------- 5: start ignored in RUN_SOBEL
    bus.thr_in    = 18'd5;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    chk("t5_thr_kept", bus.thr_out, 1234);
    chk("t5_access", bus.access_ctrl, 2);
    chk("t5_busy", bus.busy, 1);

    // ---------------- 3: timeout after 64 cycles in RUN_SOBEL
    repeat (62) tick();
    chk("t3_pre_access", bus.access_ctrl, 2);
    chk("t3_pre_err", bus.err_timeout, 0);
    tick();
    chk("t3_err", bus.err_timeout, 1);
    chk("t3_err_stage", bus.err_stage, 2);
    chk("t3_access", bus.access_ctrl, 0);
    chk("t3_busy", bus.busy, 0);
    chk("t3_frame_cnt", bus.frame_cnt, 1);
    repeat (3) tick();
    chk("t3_err_sticky", bus.err_timeout, 1);
    pulse_start(18'd50);
    chk("t3_err_cleared", bus.err_timeout, 0);
    chk("t3_stage_cleared", bus.err_stage, 0);
    chk("t3_restart_busy", bus.busy, 1);
    chk("t3_restart_thr", bus.thr_out, 50);

    // ---------------- 4: abort beats a gray done edge in the same cycle
    repeat (2) tick();
    pulse_done(0);
    tick();
    bus.done_gray = 1'b1;
    tick();
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    bus.done_gray = 1'b0;
    chk("t4_busy", bus.busy, 0);
    chk("t4_access", bus.access_ctrl, 0);
    chk("t4_nostart", bus.start_gray2sobel, 0);
    chk("t4_frame_cnt", bus.frame_cnt, 1);
    tick();
    chk("t4_nostart_late", bus.start_gray2sobel, 0);
    chk("t4_idle_access", bus.access_ctrl, 0);

    // ---------------- 6: async reset mid RUN_SOBEL, then wrap
    pulse_start(18'd9);
    repeat (2) tick();
    pulse_done(0);
    tick();
    pulse_done(1);
    tick();
    chk("t6_pre_access", bus.access_ctrl, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_access", bus.access_ctrl, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_thr", bus.thr_out, 0);
    chk("t6_rst_cnt", bus.frame_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_busy", bus.busy, 0);
    run_frame(18'd77, 1);
    chk("t6_thr_frame", bus.thr_out, 77);
    run_frame(18'd78, 2);
    run_frame(18'd79, 3);
    chk("t6_w_cnt3", bus_w.frame_cnt, 3);
    run_frame(18'd80, 4);
    chk("t6_w_wrap", bus_w.frame_cnt, 0);
    chk("t6_cnt4", bus.frame_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
